pkt_fifo_reader: RTL and testbench
==================================

Name: pkt_fifo_reader

Overview:
Read-side consumer for the team's show-ahead FIFO (fifo_rd_data valid whenever !fifo_empty; fifo_rd_en pops). Parses length-prefixed packets from the FIFO word stream. Forwards each packet on a registered valid/ready output stream with a last marker, or drops the whole packet when its header ID matches the filter. Sits between the packet-buffer FIFO and the downstream egress logic.

Parameters:
WIDTH, 32, data word width; must be >= LEN_WIDTH + ID_WIDTH
LEN_WIDTH, 8, header payload-length field width
ID_WIDTH, 8, header ID field width
CNT_WIDTH, 16, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fifo_empty  in  1  FIFO empty flag
fifo_rd_data  in  WIDTH  FIFO head word, valid when !fifo_empty
fifo_rd_en  out  1  pop FIFO head this cycle
m_valid  out  1  output word valid
m_ready  in  1  downstream accepts word
m_data  out  WIDTH  output word
m_last  out  1  final word of packet
filter_en  in  1  enable drop filter
filter_id  in  ID_WIDTH  ID to drop
pkt_count  out  CNT_WIDTH  packets forwarded
drop_count  out  CNT_WIDTH  packets dropped

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Packet format: header word, then len payload words. len = hdr[LEN_WIDTH-1:0]; id = hdr[LEN_WIDTH+ID_WIDTH-1:LEN_WIDTH]. len=0 is legal (header-only packet). The header is forwarded as word 0.
- Reset values: state HDR, m_valid=0, m_last=0, m_data=0, pkt_count=0, drop_count=0, remaining=0. fifo_rd_en=0 while rst is high.
- Output register accept condition: out_free = !m_valid || m_ready. m_valid, m_data and m_last stay stable while m_valid && !m_ready.
- fifo_rd_en is combinational and only ever asserts with !fifo_empty. Never pop when the FIFO is empty.
- Drop decision: drop = filter_en && id == filter_id. Evaluated combinationally on fifo_rd_data in HDR only. filter_en and filter_id changes mid-packet have no effect on the current packet.
- State HDR:
  - Forward case (!drop): fifo_rd_en = !fifo_empty && out_free. On pop, load the register with the header, set m_valid=1 and m_last=(len==0). If len==0: pkt_count+1, stay in HDR. Otherwise remaining=len and go to FWD.
  - Drop case (drop): fifo_rd_en = !fifo_empty, independent of m_ready. If len==0: drop_count+1, stay in HDR. Otherwise remaining=len and go to DROP.
- State FWD:
  - fifo_rd_en = !fifo_empty && out_free. On pop, load the word, m_valid=1, m_last=(remaining==1), remaining-1.
  - When remaining==1 on pop: pkt_count+1, go to HDR.
- State DROP:
  - fifo_rd_en = !fifo_empty every cycle; no output is produced.
  - When remaining==1 on pop: drop_count+1, go to HDR.
- If out_free and no new word is loaded, m_valid clears to 0 the next cycle.
- Latency: a FIFO word popped at edge N is on m_data after edge N.
- Throughput: 1 word/cycle while the FIFO is non-empty and m_ready=1, including header-to-header back-to-back packets. No bubble cycles between packets.
- Dropping proceeds at 1 word/cycle while an earlier forwarded word is stalled in the output register.
- Counters wrap modulo 2^CNT_WIDTH. Counts increment at the pop of the final word, not at downstream acceptance.
- Reset mid-packet abandons the packet: no counter update, output cleared. The FIFO is reset by its owner; resynchronisation to a header after a partial reset is the system's responsibility.
- FIFO empty mid-packet: hold state and remaining; resume when !fifo_empty.

Test Plan:
- Forward, WIDTH=32: FIFO holds 0x0000_0502, 0xA, 0xB, filter_en=0, m_ready=1 -> m_data 0x502, 0xA, 0xB on 3 consecutive cycles; m_last only on 0xB; pkt_count=1.
- Drop: same packet with filter_en=1, filter_id=5, m_ready=0 -> 3 pops in 3 cycles, m_valid stays 0, drop_count=1, pkt_count=0.
- Backpressure: forward packet 0x0000_0103, 1, 2, 3 with m_ready toggling 1,0,0,1,... -> each word held stable while stalled; no word lost or duplicated; fifo_rd_en=0 on every stall cycle.
- Back-to-back plus zero-length: 0x0000_0700 (len=0), then 0x0000_0801, 0xC -> m_last on 0x700 and on 0xC; output contiguous with no gap; pkt_count=2.
- Empty gaps and mid-packet filter change: fifo_empty=1 for 3 cycles between payload words, filter_id flipped to match mid-packet -> packet still forwarded intact; fifo_rd_en never high while empty.
- Reset mid-packet: assert rst after 1 payload word of len=4 -> next cycle m_valid=0, counters 0, state HDR; the next header in the FIFO is parsed correctly.

Source files
------------

// File: rtl/pkt_fifo_reader.sv
// Show-ahead FIFO consumer: parses length-prefixed packets, forwards them on a
// registered valid/ready stream with a last marker, or drops packets whose ID matches the filter.
module pkt_fifo_reader #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned LEN_WIDTH = 8,
  parameter int unsigned ID_WIDTH  = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_last,
  input  logic                 filter_en,
  input  logic [ID_WIDTH-1:0]  filter_id,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] drop_count
);

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic                 m_valid_q, m_valid_d;
  logic [WIDTH-1:0]     m_data_q, m_data_d;
  logic                 m_last_q, m_last_d;
  logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
  logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;

  logic [LEN_WIDTH-1:0] hdr_len;
  logic [ID_WIDTH-1:0]  hdr_id;
  logic                 drop_c;
  logic                 out_free;
  logic                 rd_en;

  assign hdr_len  = fifo_rd_data[LEN_WIDTH-1:0];
  assign hdr_id   = fifo_rd_data[LEN_WIDTH+ID_WIDTH-1:LEN_WIDTH];
  assign drop_c   = filter_en && (hdr_id == filter_id);
  assign out_free = !m_valid_q || m_ready;

  // Pop enable: drops ignore downstream backpressure, forwarding needs a free output slot.
  always_comb begin
    rd_en = 1'b0;
    case (state_q)
      ST_HDR:  rd_en = !fifo_empty && (drop_c || out_free);
      ST_FWD:  rd_en = !fifo_empty && out_free;
      ST_DROP: rd_en = !fifo_empty;
      default: rd_en = 1'b0;
    endcase
    if (rst) rd_en = 1'b0;
  end

  assign fifo_rd_en = rd_en;

  // Next-state and output-register update.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    m_valid_d    = out_free ? 1'b0 : m_valid_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    pkt_count_d  = pkt_count_q;
    drop_count_d = drop_count_q;
    case (state_q)
      ST_HDR: begin
        if (rd_en) begin
          if (!drop_c) begin
            m_valid_d = 1'b1;
            m_data_d  = fifo_rd_data;
            m_last_d  = (hdr_len == LEN_WIDTH'(0));
            if (hdr_len == LEN_WIDTH'(0)) begin
              pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
            end else begin
              remaining_d = hdr_len;
              state_d     = ST_FWD;
            end
          end else begin
            if (hdr_len == LEN_WIDTH'(0)) begin
              drop_count_d = drop_count_q + CNT_WIDTH'(1);
            end else begin
              remaining_d = hdr_len;
              state_d     = ST_DROP;
            end
          end
        end
      end
      ST_FWD: begin
        if (rd_en) begin
          m_valid_d   = 1'b1;
          m_data_d    = fifo_rd_data;
          m_last_d    = (remaining_q == LEN_WIDTH'(1));
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) begin
            pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
            state_d     = ST_HDR;
          end
        end
      end
      ST_DROP: begin
        if (rd_en) begin
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) begin
            drop_count_d = drop_count_q + CNT_WIDTH'(1);
            state_d      = ST_HDR;
          end
        end
      end
      default: state_d = ST_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_HDR;
      remaining_q  <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_pkt_fifo_reader.sv
// Directed cycle-vector bench for pkt_fifo_reader, followed by a queue-fed FIFO stream
// with irregular ready/empty patterns checked against a word scoreboard.
module tb_pkt_fifo_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic [31:0] fifo_rd_data;
  logic        fifo_rd_en;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        filter_en;
  logic [7:0]  filter_id;
  logic [15:0] pkt_count;
  logic [15:0] drop_count;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  pkt_fifo_reader #(
    .WIDTH(32), .LEN_WIDTH(8), .ID_WIDTH(8), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .filter_en(filter_en), .filter_id(filter_id),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  typedef struct {
    logic        rst;
    logic        emp;
    logic [31:0] din;
    logic        rdy;
    logic        fen;
    logic [7:0]  fid;
    logic        ren;   // expected fifo_rd_en before the edge
    logic        vld;   // expected registered outputs after the edge
    logic [31:0] dat;
    logic        lst;
    logic [15:0] pc;
    logic [15:0] dc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic e, logic [31:0] d, logic rd, logic fe, logic [7:0] fi,
                              logic xren, logic xv, logic [31:0] xd, logic xl,
                              logic [15:0] xpc, logic [15:0] xdc);
    vec_t v;
    v.rst = r; v.emp = e; v.din = d; v.rdy = rd; v.fen = fe; v.fid = fi;
    v.ren = xren; v.vld = xv; v.dat = xd; v.lst = xl; v.pc = xpc; v.dc = xdc;
    return v;
  endfunction

  task automatic check(string name, logic ok, string got, string want);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %s, required %s", name, got, want);
  endtask

  // Stream-phase FIFO model and scoreboard
  logic [31:0] fifo_q[$];
  logic [32:0] exp_q[$];
  int          pop_empty = 0;

  task automatic push_pkt(logic [31:0] hdr, logic fwd);
    int len;
    len = int'(hdr[7:0]);
    fifo_q.push_back(hdr);
    if (fwd) exp_q.push_back({len == 0, hdr});
    for (int i = 1; i <= len; i++) begin
      fifo_q.push_back(hdr + 32'(i * 16'h1111));
      if (fwd) exp_q.push_back({i == len, hdr + 32'(i * 16'h1111)});
    end
  endtask

  initial begin
    logic        ren_s;
    logic        ok;
    logic [32:0] e;
    int          cyc;

    rst = 1'b1; fifo_empty = 1'b1; fifo_rd_data = '0; m_ready = 1'b0;
    filter_en = 1'b0; filter_id = '0;

    //                rst emp din           rdy fen fid    ren vld dat           lst pc  dc
    // reset
    vq.push_back(mk(1, 0, 32'h0000_0502, 1, 0, 8'h00, 0, 0, 32'h0,        0, 0, 0));
    // forward 0x502 (id5 len2), A, B
    vq.push_back(mk(0, 0, 32'h0000_0502, 1, 0, 8'h00, 1, 1, 32'h0000_0502, 0, 0, 0));
    vq.push_back(mk(0, 0, 32'h0000_000A, 1, 0, 8'h00, 1, 1, 32'h0000_000A, 0, 0, 0));
    vq.push_back(mk(0, 0, 32'h0000_000B, 1, 0, 8'h00, 1, 1, 32'h0000_000B, 1, 1, 0));
    vq.push_back(mk(0, 1, 32'h0000_0000, 1, 0, 8'h00, 0, 0, 32'h0,        0, 1, 0));
    // drop same packet with m_ready low
    vq.push_back(mk(0, 0, 32'h0000_0502, 0, 1, 8'h05, 1, 0, 32'h0,        0, 1, 0));
    vq.push_back(mk(0, 0, 32'h0000_000A, 0, 1, 8'h05, 1, 0, 32'h0,        0, 1, 0));
    vq.push_back(mk(0, 0, 32'h0000_000B, 0, 1, 8'h05, 1, 0, 32'h0,        0, 1, 1));
    // backpressure: 0x103, 1, 2, 3 with ready 1,0,0,1,0,0,1,1
    vq.push_back(mk(0, 0, 32'h0000_0103, 1, 0, 8'h05, 1, 1, 32'h0000_0103, 0, 1, 1));
    vq.push_back(mk(0, 0, 32'h0000_0001, 0, 0, 8'h05, 0, 1, 32'h0000_0103, 0, 1, 1));
    vq.push_back(mk(0, 0, 32'h0000_0001, 0, 0, 8'h05, 0, 1, 32'h0000_0103, 0, 1, 1));
    vq.push_back(mk(0, 0, 32'h0000_0001, 1, 0, 8'h05, 1, 1, 32'h0000_0001, 0, 1, 1));
    vq.push_back(mk(0, 0, 32'h0000_0002, 0, 0, 8'h05, 0, 1, 32'h0000_0001, 0, 1, 1));
    vq.push_back(mk(0, 0, 32'h0000_0002, 0, 0, 8'h05, 0, 1, 32'h0000_0001, 0, 1, 1));
    vq.push_back(mk(0, 0, 32'h0000_0002, 1, 0, 8'h05, 1, 1, 32'h0000_0002, 0, 1, 1));
    vq.push_back(mk(0, 0, 32'h0000_0003, 1, 0, 8'h05, 1, 1, 32'h0000_0003, 1, 2, 1));
    vq.push_back(mk(0, 1, 32'h0000_0000, 0, 0, 8'h05, 0, 1, 32'h0000_0003, 1, 2, 1));
    // drop 0x501 + payload while 0x3 is still stalled in the output register
    vq.push_back(mk(0, 0, 32'h0000_0501, 0, 1, 8'h05, 1, 1, 32'h0000_0003, 1, 2, 1));
    vq.push_back(mk(0, 0, 32'h0000_00EE, 0, 1, 8'h05, 1, 1, 32'h0000_0003, 1, 2, 2));
    vq.push_back(mk(0, 1, 32'h0000_0000, 1, 0, 8'h05, 0, 0, 32'h0,        0, 2, 2));
    // back-to-back: 0x700 (len0), 0x801, 0xC, then zero-length drop 0x900
    vq.push_back(mk(0, 0, 32'h0000_0700, 1, 0, 8'h00, 1, 1, 32'h0000_0700, 1, 3, 2));
    vq.push_back(mk(0, 0, 32'h0000_0801, 1, 0, 8'h00, 1, 1, 32'h0000_0801, 0, 3, 2));
    vq.push_back(mk(0, 0, 32'h0000_000C, 1, 0, 8'h00, 1, 1, 32'h0000_000C, 1, 4, 2));
    vq.push_back(mk(0, 0, 32'h0000_0900, 1, 1, 8'h09, 1, 0, 32'h0,        0, 4, 3));
    // empty gaps with filter flipped to match mid-packet
    vq.push_back(mk(0, 0, 32'h0000_0302, 1, 0, 8'h00, 1, 1, 32'h0000_0302, 0, 4, 3));
    vq.push_back(mk(0, 1, 32'h0000_DEAD, 1, 1, 8'h03, 0, 0, 32'h0,        0, 4, 3));
    vq.push_back(mk(0, 1, 32'h0000_DEAD, 1, 1, 8'h03, 0, 0, 32'h0,        0, 4, 3));
    vq.push_back(mk(0, 1, 32'h0000_DEAD, 1, 1, 8'h03, 0, 0, 32'h0,        0, 4, 3));
    vq.push_back(mk(0, 0, 32'h0000_000D, 1, 1, 8'h03, 1, 1, 32'h0000_000D, 0, 4, 3));
    vq.push_back(mk(0, 0, 32'h0000_000E, 1, 1, 8'h03, 1, 1, 32'h0000_000E, 1, 5, 3));
    // reset mid-packet, then a fresh header parses
    vq.push_back(mk(0, 0, 32'h0000_0404, 1, 0, 8'h00, 1, 1, 32'h0000_0404, 0, 5, 3));
    vq.push_back(mk(0, 0, 32'h0000_0011, 1, 0, 8'h00, 1, 1, 32'h0000_0011, 0, 5, 3));
    vq.push_back(mk(1, 0, 32'h0000_0022, 1, 0, 8'h00, 0, 0, 32'h0,        0, 0, 0));
    vq.push_back(mk(0, 0, 32'h0000_0601, 1, 0, 8'h00, 1, 1, 32'h0000_0601, 0, 0, 0));
    vq.push_back(mk(0, 0, 32'h0000_0033, 1, 0, 8'h00, 1, 1, 32'h0000_0033, 1, 1, 0));
    vq.push_back(mk(0, 1, 32'h0000_0000, 1, 0, 8'h00, 0, 0, 32'h0,        0, 1, 0));

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst; fifo_empty = vq[i].emp; fifo_rd_data = vq[i].din;
      m_ready = vq[i].rdy; filter_en = vq[i].fen; filter_id = vq[i].fid;
      #1 ren_s = fifo_rd_en;
      @(posedge clk);
      #1;
      ok = (ren_s === vq[i].ren) && (m_valid === vq[i].vld) &&
           (pkt_count === vq[i].pc) && (drop_count === vq[i].dc) &&
           (!vq[i].vld || (m_data === vq[i].dat && m_last === vq[i].lst));
      check($sformatf("vec%0d", i), ok,
            $sformatf("ren=%0b vld=%0b data=%h last=%0b pc=%0d dc=%0d",
                      ren_s, m_valid, m_data, m_last, pkt_count, drop_count),
            $sformatf("ren=%0b vld=%0b data=%h last=%0b pc=%0d dc=%0d",
                      vq[i].ren, vq[i].vld, vq[i].dat, vq[i].lst, vq[i].pc, vq[i].dc));
    end

    // Stream phase: filter drops id 5; counters start at pc=1 dc=0
    filter_en = 1'b1; filter_id = 8'h05;
    push_pkt(32'h0000_0203, 1'b1);
    push_pkt(32'h0000_0500, 1'b0);
    push_pkt(32'h0000_0101, 1'b1);
    push_pkt(32'h0000_0502, 1'b0);
    push_pkt(32'h0000_0400, 1'b1);
    push_pkt(32'h0000_0602, 1'b1);
    cyc = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || m_valid) && cyc < 400) begin
      @(negedge clk);
      fifo_empty   = (fifo_q.size() == 0) || ($urandom_range(0, 3) == 0);
      fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
      m_ready      = ($urandom_range(0, 2) != 0);
      #1;
      ren_s = fifo_rd_en;
      if (ren_s && fifo_empty) pop_empty++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_extra", 1'b0, $sformatf("data=%h", m_data), "no more words");
        end else begin
          e = exp_q.pop_front();
          check("stream_word", {m_last, m_data} === e,
                $sformatf("data=%h last=%0b", m_data, m_last),
                $sformatf("data=%h last=%0b", e[31:0], e[32]));
        end
      end
      @(posedge clk);
      if (ren_s && fifo_q.size() != 0) void'(fifo_q.pop_front());
      cyc++;
    end
    check("stream_timeout", cyc < 400, $sformatf("%0d cycles", cyc), "under 400 cycles");
    check("stream_no_pop_empty", pop_empty == 0, $sformatf("%0d pops", pop_empty), "0 pops");
    #1;
    check("stream_counts", pkt_count === 16'd5 && drop_count === 16'd2,
          $sformatf("pc=%0d dc=%0d", pkt_count, drop_count), "pc=5 dc=2");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
